dbus_bridge: RTL
================

# dbus_bridge

Data-bus bridge that sits directly downstream of the single-cycle CPU's memory port: it consumes the CPU's ALU-computed address, store data and write strobe, and returns load data in the same cycle. It decodes the address into a word-addressed data RAM, a LED output register, a synchronized switch input port and a down-counting timer that raises an interrupt flag.

## Interface

**Parameters**
- `RAM_WORDS`, default 1024: data RAM depth in 32-bit words. Must be a power of two, ≤ 1024.
- `LED_W`, default 16: LED register width.
- `SW_W`, default 16: switch input width.

**Ports**
- `clk` input, 1: clock. All state updates occur on the rising edge.
- `rst` input, 1: reset, asynchronous, active-low.
- `addr` input, 32: byte address, driven from the CPU ALU output.
- `wdata` input, 32: store data, driven from the CPU register-file read port 2.
- `we` input, 1: write strobe, driven from the CPU `MemWrite`.
- `rdata` output, 32: load data returned to the CPU. Combinational from `addr`.
- `sw` input, `SW_W`: external switches, asynchronous to `clk`.
- `led` output, `LED_W`: LED register contents.
- `irq` output, 1: timer interrupt pending flag.

## Operation

**Address map**
- `addr[1:0]` is ignored; all accesses are whole words.
- RAM: `addr < RAM_WORDS*4`. Index is `addr[11:2]`, masked to the RAM depth.
- 0x7F00 LED (R/W): `led <= wdata[LED_W-1:0]`. Reads return the value zero-extended.
- 0x7F04 SW (RO): returns the 2-flop-synchronized `sw`, zero-extended. Writes are ignored.
- 0x7F10 CTRL: bit0 EN, bit1 AUTO, bit2 IRQ. Other bits read as 0.
- 0x7F14 PRESET (R/W): 32-bit reload value.
- 0x7F18 COUNT (RO): current counter value.
- Any other address: reads return 0; writes are ignored, with no side effects.

**Writes**
- A write takes effect on the rising edge when `we`=1.
- RAM contents are not reset. Their state after reset is unspecified.

**Timer**, evaluated every cycle
- A write to PRESET loads both PRESET and COUNT with `wdata`.
- A write to CTRL sets EN from `wdata[0]` and AUTO from `wdata[1]`.
- Writing `wdata[2]`=1 to CTRL clears IRQ. Writing 0 to bit2 leaves IRQ unchanged.
- EN=1 and COUNT>1: COUNT decrements by 1.
- EN=1 and COUNT==1 (terminal): IRQ is set to 1. COUNT loads PRESET if AUTO=1, otherwise 0.
- COUNT==0 or EN=0: COUNT holds, no IRQ.
- `irq` equals CTRL.IRQ.

**Simultaneous events**
- A PRESET write in the same cycle as a terminal count: the write wins for COUNT. IRQ is still set.
- A CTRL IRQ-clear in the same cycle as a terminal count: set wins, IRQ stays 1.
- A CTRL write clearing EN in the same cycle as a terminal count: the terminal action still occurs. This is because timer logic uses the pre-edge EN.

## Timing

- `rdata` is purely combinational from `addr` and current register/RAM state, giving zero-cycle load latency as the single-cycle CPU requires. A read of a location written in the same cycle returns the old value.
- Store latency is one edge.
- The SW read reflects `sw` sampled two rising edges earlier.
- PRESET=N with EN=1 set on edge 0: COUNT reaches 1 after N−1 edges, and IRQ asserts on edge N.
- With AUTO=1, the period is N cycles.
- Reset (`rst`=0, asynchronous, at any time including mid-count) forces the following values immediately:
  - `led`=0.
  - CTRL=0, PRESET=0, COUNT=0.
  - `irq`=0.
  - Both SW sync stages to 0.
- After `rst` rises, the block behaves normally from the next edge. There is no residual timer state.

## Configuration

- Macro `DBUS_TIMER_EN`.
- Defined: the timer and `irq` are built as described above.
- Undefined: no timer logic is generated. Addresses 0x7F10–0x7F18 decode as unmapped (reads return 0, writes are ignored), and `irq` is tied to 0.
- RAM, LED and SW behaviour are identical in both builds.

## Test plan

- **Reset:** assert `rst`=0 mid-count with COUNT=5 → `led`=0, `irq`=0 and COUNT reads 0 immediately. After release, a CTRL read returns 0.
- **RAM:** write 0xDEADBEEF to 0x0000_0010. Read 0x10 and 0x13 → both return 0xDEADBEEF. Read 0x14 → returns the unwritten/previously written value, not 0xDEADBEEF.
- **LED/SW/unmapped:**
  - Write 0x1234_A5A5 to 0x7F00 → `led`=0xA5A5.
  - Drive `sw`=0x00F0 → the SW read returns 0xF0 two edges later.
  - Write to 0x7F08, then read it → returns 0.
- **One-shot timer:** PRESET=3, CTRL=0x1 → COUNT reads 3,2,1,0. `irq` rises on the edge COUNT becomes 0, and COUNT holds 0.
- **Auto-reload with clear race:** PRESET=2, CTRL=0x3 → `irq` sets every 2 cycles. A CTRL write of 0x7 on a terminal cycle → `irq` remains 1. The same write on a non-terminal cycle → `irq`=0.
- **Timer compiled out:** build without `DBUS_TIMER_EN`, write 0x1 to 0x7F10 → a read of 0x7F10 returns 0 and `irq` stays 0 for 100 cycles.

Source files
------------

// File: rtl/dbus_bridge.sv
// Data-bus bridge for a single-cycle CPU: word RAM, LED register, synchronized switches
// and an optional down-counting timer with interrupt flag (built when DBUS_TIMER_EN is defined).
module dbus_bridge #(
  parameter int RAM_WORDS = 1024,
  parameter int LED_W     = 16,
  parameter int SW_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  output logic [31:0]      rdata,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led,
  output logic             irq
);

  localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

  // Word addresses (byte address >> 2) of the peripheral registers.
  localparam logic [29:0] A_LED    = 30'h0000_1FC0;
  localparam logic [29:0] A_SW     = 30'h0000_1FC1;
`ifdef DBUS_TIMER_EN
  localparam logic [29:0] A_CTRL   = 30'h0000_1FC4;
  localparam logic [29:0] A_PRESET = 30'h0000_1FC5;
  localparam logic [29:0] A_COUNT  = 30'h0000_1FC6;
`endif

  logic [29:0]   word;
  logic          hit_ram;
  logic [AW-1:0] ram_idx;

  assign word    = addr[31:2];
  assign hit_ram = ({1'b0, addr} < RAM_BYTES);
  assign ram_idx = addr[2 +: AW];

  logic [31:0] mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (we && hit_ram) begin
      mem[ram_idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led <= '0;
    end else if (we && word == A_LED) begin
      led <= wdata[LED_W-1:0];
    end
  end

  // Two-flop synchronizer for the asynchronous switch inputs.
  logic [SW_W-1:0] sw_p0, sw_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= sw;
      sw_p1 <= sw_p0;
    end
  end

`ifdef DBUS_TIMER_EN
  logic        en, auto_rl, irq_q;
  logic [31:0] preset, count;
  logic        wr_ctrl, wr_preset, term;

  assign wr_ctrl   = we && (word == A_CTRL);
  assign wr_preset = we && (word == A_PRESET);
  // Terminal action depends only on pre-edge EN, so a same-cycle disable cannot suppress it.
  assign term      = en && (count == 32'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en      <= 1'b0;
      auto_rl <= 1'b0;
      irq_q   <= 1'b0;
      preset  <= '0;
      count   <= '0;
    end else begin
      if (wr_ctrl) begin
        en      <= wdata[0];
        auto_rl <= wdata[1];
      end
      if (term) begin
        irq_q <= 1'b1;
      end else if (wr_ctrl && wdata[2]) begin
        irq_q <= 1'b0;
      end
      if (wr_preset) begin
        preset <= wdata;
      end
      if (wr_preset) begin
        count <= wdata;
      end else if (term) begin
        count <= auto_rl ? preset : 32'd0;
      end else if (en && count > 32'd1) begin
        count <= count - 32'd1;
      end
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (hit_ram) begin
      rdata = mem[ram_idx];
    end else if (word == A_LED) begin
      rdata[LED_W-1:0] = led;
    end else if (word == A_SW) begin
      rdata[SW_W-1:0] = sw_p1;
`ifdef DBUS_TIMER_EN
    end else if (word == A_CTRL) begin
      rdata[2:0] = {irq_q, auto_rl, en};
    end else if (word == A_PRESET) begin
      rdata = preset;
    end else if (word == A_COUNT) begin
      rdata = count;
`endif
    end
  end

endmodule
